// File: rtl/shift_rx_pkg.sv
// shift_rx_pkg: shared state encoding and default frame width for the shift receiver
package shift_rx_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/shift_reg_sync.sv
// shift_reg_sync: WIDTH-bit left-shift register with sync reset, clear and shift enable
module shift_reg_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH-1:0] sr_q, sr_d;
  assign q_next = {sr_q[WIDTH-2:0], din};
  // clear beats shift; hold when not enabled
  always_comb sr_d = clr ? '0 : en ? q_next : sr_q;
  // state register
  always_ff @(posedge clk) sr_q <= rst ? '0 : sr_d;
endmodule

// File: rtl/shift_rx_ctrl.sv
// shift_rx_ctrl: tick-paced serial-in/parallel-out frame sequencer with valid/ready output; parity check enabled by SHIFT_RX_PARITY_CHECK_EN
module shift_rx_ctrl
  import shift_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Clk_EN,
  input  logic             start,
  input  logic             abort,
  input  logic             in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);
  localparam int CNT_W = $clog2(WIDTH);
`ifdef SHIFT_RX_PARITY_CHECK_EN
  localparam state_t AFTER_SHIFT = PARITY;
`else
  localparam state_t AFTER_SHIFT = DONE;
`endif
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d, sr_next;
  logic out_valid_q, out_valid_d, busy_q, busy_d, overrun_q, overrun_d, parity_err_q, parity_err_d;
  logic in_frame, cancel, last, sr_clr, sr_en;
  assign in_frame = state_q == SHIFT || state_q == PARITY;
  assign cancel   = in_frame && abort;
  assign last     = cnt_q == CNT_W'(WIDTH - 1);
  assign sr_clr   = cancel || (state_q == IDLE && Clk_EN && start);
  assign sr_en    = Clk_EN && state_q == SHIFT;
  shift_reg_sync #(.WIDTH(WIDTH)) u_sr (
    .clk    (clk),
    .rst    (rst),
    .clr    (sr_clr),
    .en     (sr_en),
    .din    (in),
    .q_next (sr_next)
  );
  // next-state, counter and output-register logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    overrun_d    = overrun_q;
    parity_err_d = parity_err_q;
    if (cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      if (Clk_EN && start) begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
    end else if (state_q == SHIFT) begin
      if (Clk_EN) begin
        cnt_d      = last ? cnt_q : cnt_q + 1'b1;
        data_out_d = last ? sr_next : data_out_q;
        state_d    = last ? AFTER_SHIFT : SHIFT;
      end
    end else if (state_q == PARITY) begin
      if (Clk_EN) begin
        parity_err_d = ^{data_out_q, in};
        state_d      = DONE;
      end
    end else begin
      overrun_d = overrun_q | (Clk_EN & start);
      state_d   = (out_valid_q && out_ready) ? IDLE : DONE;
    end
    out_valid_d = state_d == DONE;
    busy_d      = state_d == SHIFT || state_d == PARITY;
  end
  // all state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;
endmodule
